// File: rtl/visible_pkg.sv
// Shared types for the visible_top demo: operation encodings and default width.
package visible_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_NOTA  = 3'b101,
    OP_PASSA = 3'b110,
    OP_PASSB = 3'b111
  } op_e;

endpackage

// File: rtl/visible_alu_comb.sv
// Combinational ALU core: produces the next result and carry/borrow from a, b, op.
module visible_alu_comb
  import visible_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] next_c,
  output logic             next_carry
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // One extra bit: the sum's MSB is carry-out, the difference's MSB is the borrow (a < b).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    next_c     = '0;
    next_carry = 1'b0;
    unique case (op)
      OP_ADD:   {next_carry, next_c} = sum;
      OP_SUB:   {next_carry, next_c} = diff;
      OP_AND:   next_c = a & b;
      OP_OR:    next_c = a | b;
      OP_XOR:   next_c = a ^ b;
      OP_NOTA:  next_c = ~a;
      OP_PASSA: next_c = a;
      OP_PASSB: next_c = b;
      default:  next_c = '0;
    endcase
  end

endmodule

// File: rtl/visible_top_unit.sv
// Registered 3-bit ALU: result, carry and zero flag all update on the same edge.
module visible_top_unit
  import visible_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] c,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH-1:0] c_d, c_q;
  logic             carry_d, carry_q;
  logic             zero_d, zero_q;

  visible_alu_comb #(.WIDTH(WIDTH)) u_alu (
    .a          (a),
    .b          (b),
    .op         (op_e'(op)),
    .next_c     (c_d),
    .next_carry (carry_d)
  );

  // Zero derives from the next result so it never lags c.
  always_comb begin
    zero_d = (c_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      c_q     <= c_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign c     = c_q;
  assign carry = carry_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_visible_top_unit.sv
// Directed bench for visible_top_unit with hand-computed expected results.
module tb_visible_top_unit;

  logic       clk;
  logic       rst_n;
  logic [2:0] a, b, op;
  logic [2:0] c;
  logic       carry, zero;

  int vectors;
  int miscompares;

  visible_top_unit #(.WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .op    (op),
    .c     (c),
    .carry (carry),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input logic rn, input logic [2:0] ia, input logic [2:0] ib,
                       input logic [2:0] iop);
    rst_n = rn;
    a     = ia;
    b     = ib;
    op    = iop;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [2:0] ec, input logic ecy,
                       input logic ez);
    vectors++;
    assert (c === ec) else begin
      miscompares++;
      $error("FAIL %s c: got %0d want %0d", tag, c, ec);
    end
    vectors++;
    assert (carry === ecy) else begin
      miscompares++;
      $error("FAIL %s carry: got %b want %b", tag, carry, ecy);
    end
    vectors++;
    assert (zero === ez) else begin
      miscompares++;
      $error("FAIL %s zero: got %b want %b", tag, zero, ez);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // reset held two edges with live operands
    apply(1'b0, 3'd5, 3'd6, 3'b000); check("rst1", 3'd0, 1'b0, 1'b1);
    apply(1'b0, 3'd5, 3'd6, 3'b000); check("rst2", 3'd0, 1'b0, 1'b1);
    apply(1'b1, 3'd5, 3'd6, 3'b000); check("rst_release_5p6", 3'd3, 1'b1, 1'b0);

    // ADD basic
    apply(1'b1, 3'd0, 3'd0, 3'b000); check("add_0p0", 3'd0, 1'b0, 1'b1);
    apply(1'b1, 3'd1, 3'd1, 3'b000); check("add_1p1", 3'd2, 1'b0, 1'b0);
    #3;                              check("add_1p1_hold", 3'd2, 1'b0, 1'b0);

    // ADD wrap
    apply(1'b1, 3'd7, 3'd1, 3'b000); check("add_7p1", 3'd0, 1'b1, 1'b1);
    apply(1'b1, 3'd7, 3'd7, 3'b000); check("add_7p7", 3'd6, 1'b1, 1'b0);

    // SUB
    apply(1'b1, 3'd2, 3'd5, 3'b001); check("sub_2m5", 3'd5, 1'b1, 1'b0);
    apply(1'b1, 3'd4, 3'd4, 3'b001); check("sub_4m4", 3'd0, 1'b0, 1'b1);
    apply(1'b1, 3'd0, 3'd1, 3'b001); check("sub_0m1", 3'd7, 1'b1, 1'b0);
    apply(1'b1, 3'd6, 3'd2, 3'b001); check("sub_6m2", 3'd4, 1'b0, 1'b0);

    // logic ops on a=6 b=3
    apply(1'b1, 3'd6, 3'd3, 3'b010); check("and", 3'd2, 1'b0, 1'b0);
    apply(1'b1, 3'd6, 3'd3, 3'b011); check("or", 3'd7, 1'b0, 1'b0);
    apply(1'b1, 3'd6, 3'd3, 3'b100); check("xor", 3'd5, 1'b0, 1'b0);
    apply(1'b1, 3'd6, 3'd3, 3'b101); check("nota", 3'd1, 1'b0, 1'b0);
    apply(1'b1, 3'd6, 3'd3, 3'b110); check("passa", 3'd6, 1'b0, 1'b0);
    apply(1'b1, 3'd6, 3'd3, 3'b111); check("passb", 3'd3, 1'b0, 1'b0);

    // logic-op corners: zero results and inverted zero
    apply(1'b1, 3'd5, 3'd2, 3'b010); check("and_zero", 3'd0, 1'b0, 1'b1);
    apply(1'b1, 3'd0, 3'd0, 3'b101); check("nota_0", 3'd7, 1'b0, 1'b0);
    apply(1'b1, 3'd7, 3'd7, 3'b100); check("xor_zero", 3'd0, 1'b0, 1'b1);

    // mid-stream reset pulse between back-to-back ADDs
    apply(1'b1, 3'd2, 3'd3, 3'b000); check("mid_add_2p3", 3'd5, 1'b0, 1'b0);
    apply(1'b0, 3'd4, 3'd5, 3'b000); check("mid_rst", 3'd0, 1'b0, 1'b1);
    apply(1'b1, 3'd3, 3'd3, 3'b000); check("mid_resume_3p3", 3'd6, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
